serial_subtractor_ctrl: RTL and testbench

//   Bit-serial N-bit unsigned subtractor controller: time-multiplexes one 1-bit subtract cell over WIDTH cycles.

---
 rtl/serial_subtractor_pkg.sv | 16 +
 rtl/serial_sub_cell.sv | 21 ++
 rtl/serial_subtractor_ctrl.sv | 117 +++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: controller state encoding
// and the rule that sizes the bit-index counter.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter must index bits 0..WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_cell.sv
// One-bit full subtractor built from two half-subtract stages; the borrow-out
// is the OR of the two stage borrows.
module serial_sub_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic hs1_d;
    logic hs1_b;
    logic hs2_b;

    assign hs1_d = a_i ^ b_i;
    assign hs1_b = ~a_i & b_i;
    assign d     = hs1_d ^ bin;
    assign hs2_b = ~hs1_d & bin;
    assign bout  = hs1_b | hs2_b;

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: one subtract cell walked LSB-first over WIDTH
// cycles, operands in and result out over valid/ready handshakes.
module serial_subtractor_ctrl
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sh_a_q;
    logic [WIDTH-1:0] sh_b_q;
    logic [WIDTH-1:0] diff_q;
    logic             br_q;
    logic             borrow_q;
    logic             zero_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             cell_d;
    logic             cell_bout;
    logic [WIDTH-1:0] diff_d;
    logic             last_bit;

    serial_sub_cell u_cell (
        .a_i  (sh_a_q[0]),
        .b_i  (sh_b_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Result bits enter at the MSB end, so after WIDTH shifts bit 0 holds the LSB.
    assign diff_d   = {cell_d, diff_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // NOTE: state updates use non-blocking assignments so every register samples
    // pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            diff_q      <= '0;
            br_q        <= 1'b0;
            borrow_q    <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        sh_a_q   <= a;
                        sh_b_q   <= b;
                        br_q     <= 1'b0;
                        cnt_q    <= '0;
                        diff_q   <= '0;
                        borrow_q <= 1'b0;
                        zero_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    diff_q <= diff_d;
                    sh_a_q <= sh_a_q >> 1;
                    sh_b_q <= sh_b_q >> 1;
                    br_q   <= cell_bout;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        borrow_q    <= cell_bout;
                        zero_q      <= (diff_d == '0);
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign zero      = zero_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for the bit-serial subtractor: directed cases on an 8-bit
// instance plus random held-valid streams at widths 8, 2 and 16.
module tb_serial_subtractor_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic int width_of(input int idx);
        return (idx == 0) ? 8 : ((idx == 1) ? 2 : 16);
    endfunction

    // Reference: plain unsigned arithmetic, packed as {zero, borrow, diff}.
    function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] d;
        d = x - y;
        return {d == 8'd0, x < y, d};
    endfunction

    // ---------------- directed 8-bit instance ----------------
    logic       rst, in_valid, in_ready, out_valid, out_ready, borrow, zero, busy;
    logic [7:0] a, b, diff;
    logic [9:0] exp_q[$];
    logic [9:0] e_mon;

    serial_subtractor_ctrl #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow), .zero(zero), .busy(busy)
    );

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e_mon = exp_q.pop_front();
                check("sb_diff", diff, e_mon[7:0]);
                check("sb_borrow", borrow, e_mon[8]);
                check("sb_zero", zero, e_mon[9]);
            end
        end
    end

    task automatic send(input logic [7:0] av, input logic [7:0] bv, input bit push);
        int g;
        g = 0;
        in_valid = 1'b1;
        a = av;
        b = bv;
        while (!in_ready && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        check("send_ready", in_ready, 1);
        @(posedge clk);
        if (push) exp_q.push_back(model8(av, bv));
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv);
        int g;
        send(av, bv, 1'b1);
        g = 0;
        while (!in_ready && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        check("op_complete", in_ready, 1);
    endtask

    // ---------------- random streams at several widths ----------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_stream
        localparam int W = width_of(gi);
        logic         srst, iv, ir, ov, ordy, brw, zr, bsy;
        logic [W-1:0] av, bv, df, de;
        logic [W+1:0] sq[$];
        logic [W+1:0] e;
        int           got  = 0;
        bit           fed  = 1'b0;
        bit           done = 1'b0;

        serial_subtractor_ctrl #(.WIDTH(W)) u_dut (
            .clk(clk), .rst(srst), .in_valid(iv), .in_ready(ir),
            .a(av), .b(bv), .out_valid(ov), .out_ready(ordy),
            .diff(df), .borrow(brw), .zero(zr), .busy(bsy)
        );

        always @(negedge clk) begin
            if (!srst && ov && ordy) begin
                check($sformatf("w%0d_sb_nonempty", W), sq.size() != 0, 1);
                if (sq.size() != 0) begin
                    e = sq.pop_front();
                    check($sformatf("w%0d_diff", W), df, e[W-1:0]);
                    check($sformatf("w%0d_borrow", W), brw, e[W]);
                    check($sformatf("w%0d_zero", W), zr, e[W+1]);
                end
                got++;
            end
        end

        initial begin
            int g;
            srst = 1'b1; iv = 1'b0; ordy = 1'b0; av = '0; bv = '0;
            repeat (3) @(posedge clk);
            #1 srst = 1'b0;
            fork
                begin
                    for (int k = 0; k < 50; k++) begin
                        av = W'($urandom);
                        bv = W'($urandom);
                        iv = 1'b1;
                        g = 0;
                        while (!ir && g < 1000) begin
                            @(posedge clk); #1;
                            g++;
                        end
                        check($sformatf("w%0d_accept_ready", W), ir, 1);
                        @(posedge clk);
                        de = av - bv;
                        sq.push_back({de == '0, av < bv, de});
                        #1;
                    end
                    iv = 1'b0;
                    fed = 1'b1;
                end
                begin
                    while (!fed) begin
                        ordy = 1'($urandom_range(0, 1));
                        @(posedge clk); #1;
                    end
                    ordy = 1'b1;
                end
            join
            g = 0;
            while (sq.size() != 0 && g < 2000) begin
                @(posedge clk);
                g++;
            end
            #1;
            check($sformatf("w%0d_drained", W), sq.size(), 0);
            check($sformatf("w%0d_result_count", W), got, 50);
            done = 1'b1;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int         lat;
        int         g;
        logic [9:0] e;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        check("rst_zero", zero, 0);

        // Latency: result appears exactly WIDTH edges after the accept edge.
        send(8'd100, 8'd37, 1'b1);
        check("run_busy", busy, 1);
        check("run_in_ready", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 8);
        @(posedge clk); #1;
        check("post_hs_out_valid", out_valid, 0);
        check("post_hs_in_ready", in_ready, 1);

        run_op(8'd5, 8'd9);
        run_op(8'd0, 8'd255);
        run_op(8'd170, 8'd170);
        run_op(8'd255, 8'd0);

        // Backpressure: result held while out_ready is low; in_valid ignored.
        out_ready = 1'b0;
        send(8'd200, 8'd55, 1'b1);
        e = model8(8'd200, 8'd55);
        g = 0;
        while (!out_valid && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        check("bp_out_valid_rise", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a = 8'(i + 1);
            b = 8'(i * 3);
            @(posedge clk); #1;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_diff", diff, e[7:0]);
            check("bp_hold_borrow", borrow, e[8]);
            check("bp_hold_zero", zero, e[9]);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);

        // Abort mid-run: reset after bit 3 has been processed.
        send(8'hF3, 8'h5A, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_pre_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow, 0);
        run_op(8'd20, 8'd7);

        g = 0;
        while (!(g_stream[0].done && g_stream[1].done && g_stream[2].done) && g < 30000) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("streams_finished", g_stream[0].done && g_stream[1].done && g_stream[2].done, 1);
        check("directed_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
